gate_pair_sequencer: RTL and testbench
======================================

GATE_PAIR_SEQUENCER -- requirements
Module: gate_pair_sequencer

Interface
REQ-001 SHALL have parameter NUM_QUBITS, default 3: qubit count; the state vector holds 2^NUM_QUBITS complex_t amplitudes.
REQ-002 SHALL have parameter APP_LATENCY, default 4: fixed cycle latency of the downstream gate_applicator.
REQ-003 SHALL have clk  in  1: single clock; all logic on the rising edge.
REQ-004 SHALL have rst  in  1: asynchronous, active-high reset.
REQ-005 SHALL have start  in  1: request to apply the currently loaded gate.
REQ-006 SHALL have target_qubit  in  $clog2(NUM_QUBITS) (min 1): index of the target qubit, sampled with start.
REQ-007 SHALL have busy  out  1, done  out  1 (one-cycle pulse), err  out  1 (valid with done).
REQ-008 SHALL have rd_en  out  1, rd_addr_a and rd_addr_b  out  NUM_QUBITS each: dual-read state RAM port; rd_data_a and rd_data_b  in  complex_t, valid 1 cycle after rd_en.
REQ-009 SHALL have app_in_1 and app_in_2  out  complex_t: amplitudes to the applicator.
REQ-010 SHALL have app_out_1 and app_out_2  in  complex_t: applicator results.
REQ-011 SHALL have wr_en  out  1, wr_addr_a and wr_addr_b  out  NUM_QUBITS each, and wr_data_a and wr_data_b  out  complex_t: dual-write state RAM port.
REQ-012 SHALL have perf_cycles  out  16: busy-cycle count of the last operation (see Configuration).

Function
REQ-013 SHALL implement FSM IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
REQ-014 IDLE: start=1 with target_qubit<NUM_QUBITS SHALL go to ISSUE; start=1 with target_qubit>=NUM_QUBITS SHALL go to DONE with err=1 and no RAM access.
REQ-015 start SHALL be ignored in every state except IDLE.
REQ-016 ISSUE SHALL assert rd_en for exactly P=2^(NUM_QUBITS-1) consecutive cycles, with pair index j=0..P-1.
REQ-017 For each pair, rd_addr_a SHALL equal j with a 0 inserted at bit target_qubit, and rd_addr_b SHALL equal rd_addr_a with bit target_qubit set.
REQ-018 rd_data SHALL be registered into app_in_1/app_in_2 one cycle after arrival (read at cycle t, app_in valid at t+2).
REQ-019 app_out SHALL be written back at cycle t+2+APP_LATENCY: wr_en=1, wr_data_a=app_out_1, wr_data_b=app_out_2, with addresses delayed from the read through a valid/address shift pipeline of depth 2+APP_LATENCY.
REQ-020 Throughput SHALL be one pair per cycle with no stalls; pairs within one gate are disjoint, so no hazard logic is needed.
REQ-021 DRAIN SHALL persist until the pipeline is empty; DONE SHALL last one cycle with done=1 and busy=0.
REQ-022 busy SHALL be 1 in ISSUE and DRAIN and 0 otherwise; err SHALL hold until the next accepted start.
REQ-023 With start accepted at edge 0, rd_en SHALL be high in cycles 1..P, wr_en high in cycles 7..P+6, and done high in cycle P+7 (APP_LATENCY=4).
REQ-024 wr_en SHALL never assert for a cycle without a valid read, and SHALL never assert in IDLE or DONE.

Reset
REQ-025 rst SHALL force: state IDLE, busy/done/err/rd_en/wr_en=0, all addresses, app_in and wr_data=0, pipeline valids cleared, and perf_cycles=0.
REQ-026 rst asserted mid-operation SHALL abort it; no wr_en SHALL follow reset release until a new start is accepted.

Configuration
REQ-027 With macro GATE_SEQ_PERF_COUNTER_EN defined, perf_cycles SHALL count busy cycles of an operation, saturating at 16'hFFFF, cleared on accepted start, and held after done.
REQ-028 Without GATE_SEQ_PERF_COUNTER_EN, perf_cycles SHALL be tied to 0 and no counter logic SHALL be synthesized.

Verification
REQ-029 NUM_QUBITS=3, target 0, start -> read/write pairs (0,1),(2,3),(4,5),(6,7) in order; rd_en cycles 1-4, wr_en cycles 7-10, done at cycle 11.
REQ-030 target 2 -> pairs (0,4),(1,5),(2,6),(3,7); with an applicator model U=[[0,1],[1,0]] and RAM preloaded amp[i].re=i, final amp[i].re equals i XOR 4.
REQ-031 target_qubit=3 -> done and err at cycle 1, zero rd_en/wr_en, busy never high.
REQ-032 start held high throughout an operation -> exactly one operation; a second start after done triggers a new, correct operation.
REQ-033 rst pulsed at cycle 3 of an operation -> outputs immediately 0, no wr_en afterwards, and the next start completes normally.
REQ-034 With GATE_SEQ_PERF_COUNTER_EN, target 0 -> perf_cycles=10 after done; without the macro -> perf_cycles=0.

Source files
------------

// File: rtl/gate_pair_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : gate_pair_sequencer_pkg / gate_pair_sequencer_if
// Description : Shared complex amplitude type, plus the bundle of control,
//               state-RAM and applicator signals used by gate_pair_sequencer.
//               The slave modport is the sequencer's view. The master modport
//               is the environment's view (controller, RAM and applicator).
// Ports       : start, target_qubit        -> sequencer (operation request)
//               busy, done, err, perf_cycles <- sequencer (status)
//               rd_en, rd_addr_a/b          <- sequencer; rd_data_a/b -> sequencer
//               app_in_1/2                  <- sequencer; app_out_1/2 -> sequencer
//               wr_en, wr_addr_a/b, wr_data_a/b <- sequencer
// Revision    : 1.0 - initial release
// ============================================================================

package gate_pair_sequencer_pkg;
  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
  } complex_t;
endpackage

interface gate_pair_sequencer_if #(
  parameter int NUM_QUBITS = 3
);
  localparam int TQ_W = ($clog2(NUM_QUBITS) < 1) ? 1 : $clog2(NUM_QUBITS);

  logic                              start;
  logic [TQ_W-1:0]                   target_qubit;
  logic                              busy;
  logic                              done;
  logic                              err;
  logic                              rd_en;
  logic [NUM_QUBITS-1:0]             rd_addr_a;
  logic [NUM_QUBITS-1:0]             rd_addr_b;
  gate_pair_sequencer_pkg::complex_t rd_data_a;
  gate_pair_sequencer_pkg::complex_t rd_data_b;
  gate_pair_sequencer_pkg::complex_t app_in_1;
  gate_pair_sequencer_pkg::complex_t app_in_2;
  gate_pair_sequencer_pkg::complex_t app_out_1;
  gate_pair_sequencer_pkg::complex_t app_out_2;
  logic                              wr_en;
  logic [NUM_QUBITS-1:0]             wr_addr_a;
  logic [NUM_QUBITS-1:0]             wr_addr_b;
  gate_pair_sequencer_pkg::complex_t wr_data_a;
  gate_pair_sequencer_pkg::complex_t wr_data_b;
  logic [15:0]                       perf_cycles;

  modport master (
    output start, target_qubit, rd_data_a, rd_data_b, app_out_1, app_out_2,
    input  busy, done, err, rd_en, rd_addr_a, rd_addr_b, app_in_1, app_in_2,
    input  wr_en, wr_addr_a, wr_addr_b, wr_data_a, wr_data_b, perf_cycles
  );

  modport slave (
    input  start, target_qubit, rd_data_a, rd_data_b, app_out_1, app_out_2,
    output busy, done, err, rd_en, rd_addr_a, rd_addr_b, app_in_1, app_in_2,
    output wr_en, wr_addr_a, wr_addr_b, wr_data_a, wr_data_b, perf_cycles
  );
endinterface

`default_nettype wire

// File: rtl/gate_pair_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : gate_pair_sequencer
// Description : Walks all amplitude pairs (i, i | 1<<target) of a
//               2^NUM_QUBITS state vector. Each pair is read from a dual-port
//               state RAM, fed to a fixed-latency gate applicator, and written
//               back, at one pair per cycle with no stalls.
//               FSM: IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
// Ports       : clk, rst (asynchronous, active-high)
//               bus : gate_pair_sequencer_if.slave. It carries start/target,
//                     status, the RAM read/write ports and the applicator links.
// Config      : `define GATE_SEQ_PERF_COUNTER_EN makes perf_cycles a
//               saturating busy-cycle counter. Otherwise it is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================

module gate_pair_sequencer
  import gate_pair_sequencer_pkg::*;
#(
  parameter int NUM_QUBITS  = 3,
  parameter int APP_LATENCY = 4
) (
  input  wire logic          clk,
  input  wire logic          rst,
  gate_pair_sequencer_if.slave bus
);

  localparam int TQ_W  = ($clog2(NUM_QUBITS) < 1) ? 1 : $clog2(NUM_QUBITS);
  localparam int P     = 2 ** (NUM_QUBITS - 1);
  localparam int J_W   = (NUM_QUBITS > 1) ? NUM_QUBITS - 1 : 1;
  // The read takes 1 cycle, the app_in register adds 1, then the applicator latency.
  localparam int DEPTH = 2 + APP_LATENCY;

  localparam logic [J_W-1:0]  J_LAST = J_W'(P - 1);
  localparam logic [TQ_W:0]   NQ_LIM = (TQ_W + 1)'(NUM_QUBITS);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]                             state_q, state_d;
  logic [J_W-1:0]                         j_q, j_d;
  logic [TQ_W-1:0]                        tgt_q, tgt_d;
  logic                                   err_q, err_d;
  logic [DEPTH-1:0]                       vld_q, vld_d;
  logic [DEPTH-1:0][NUM_QUBITS-1:0]       addr_a_q, addr_a_d;
  logic [DEPTH-1:0][NUM_QUBITS-1:0]       addr_b_q, addr_b_d;
  complex_t                               app_in_1_q, app_in_1_d;
  complex_t                               app_in_2_q, app_in_2_d;

  logic                                   start_idle;
  logic                                   tgt_ok;
  logic                                   issue;
  logic [NUM_QUBITS-1:0]                  jx;
  logic [NUM_QUBITS-1:0]                  low_mask;
  logic [NUM_QUBITS-1:0]                  pair_a;
  logic [NUM_QUBITS-1:0]                  pair_b;
  logic [NUM_QUBITS-1:0]                  rd_addr_a_w;
  logic [NUM_QUBITS-1:0]                  rd_addr_b_w;

  assign start_idle = (state_q == S_IDLE) && bus.start;
  assign tgt_ok     = ({1'b0, bus.target_qubit} < NQ_LIM);
  assign issue      = (state_q == S_ISSUE);

  // Pair index j with a zero inserted at bit tgt_q. The bits below the target
  // stay where they are, and the bits at or above it move up one position.
  assign jx          = NUM_QUBITS'(j_q);
  assign low_mask    = (NUM_QUBITS'(1) << tgt_q) - NUM_QUBITS'(1);
  assign pair_a      = ((jx & ~low_mask) << 1) | (jx & low_mask);
  assign pair_b      = pair_a | (NUM_QUBITS'(1) << tgt_q);
  assign rd_addr_a_w = issue ? pair_a : '0;
  assign rd_addr_b_w = issue ? pair_b : '0;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = tgt_ok ? S_ISSUE : S_DONE;
        end
      end
      S_ISSUE: begin
        if (j_q == J_LAST) begin
          state_d = S_DRAIN;
        end
      end
      // Leave DRAIN once the last write-back is on the bus this cycle.
      S_DRAIN: begin
        if (vld_d == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic
  // --------------------------------------------------------------------------
  always_comb begin
    bus.busy      = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    bus.done      = (state_q == S_DONE);
    bus.err       = err_q;
    bus.rd_en     = issue;
    bus.rd_addr_a = rd_addr_a_w;
    bus.rd_addr_b = rd_addr_b_w;
    bus.app_in_1  = app_in_1_q;
    bus.app_in_2  = app_in_2_q;
    bus.wr_en     = vld_q[DEPTH-1];
    bus.wr_addr_a = vld_q[DEPTH-1] ? addr_a_q[DEPTH-1] : '0;
    bus.wr_addr_b = vld_q[DEPTH-1] ? addr_b_q[DEPTH-1] : '0;
    bus.wr_data_a = vld_q[DEPTH-1] ? bus.app_out_1 : '0;
    bus.wr_data_b = vld_q[DEPTH-1] ? bus.app_out_2 : '0;
  end

  // --------------------------------------------------------------------------
  // Datapath: pair counter, error flag, app_in capture, valid/address pipeline
  // --------------------------------------------------------------------------
  always_comb begin
    j_d        = j_q;
    tgt_d      = tgt_q;
    err_d      = err_q;
    app_in_1_d = app_in_1_q;
    app_in_2_d = app_in_2_q;

    if (start_idle) begin
      tgt_d = bus.target_qubit;
      j_d   = '0;
      err_d = !tgt_ok;
    end else if (issue) begin
      j_d = j_q + J_W'(1);
    end

    // RAM data returns while vld_q[0] is set. Register it toward the applicator.
    if (vld_q[0]) begin
      app_in_1_d = bus.rd_data_a;
      app_in_2_d = bus.rd_data_b;
    end

    vld_d    = {vld_q[DEPTH-2:0], issue};
    addr_a_d = {addr_a_q[DEPTH-2:0], rd_addr_a_w};
    addr_b_d = {addr_b_q[DEPTH-2:0], rd_addr_b_w};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      j_q        <= '0;
      tgt_q      <= '0;
      err_q      <= 1'b0;
      vld_q      <= '0;
      addr_a_q   <= '0;
      addr_b_q   <= '0;
      app_in_1_q <= '0;
      app_in_2_q <= '0;
    end else begin
      j_q        <= j_d;
      tgt_q      <= tgt_d;
      err_q      <= err_d;
      vld_q      <= vld_d;
      addr_a_q   <= addr_a_d;
      addr_b_q   <= addr_b_d;
      app_in_1_q <= app_in_1_d;
      app_in_2_q <= app_in_2_d;
    end
  end

  // --------------------------------------------------------------------------
  // Busy-cycle counter
  // --------------------------------------------------------------------------
`ifdef GATE_SEQ_PERF_COUNTER_EN
  logic [15:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (start_idle) begin
      perf_d = '0;
    end else if (((state_q == S_ISSUE) || (state_q == S_DRAIN)) && (perf_q != 16'hFFFF)) begin
      perf_d = perf_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign bus.perf_cycles = perf_q;
`else
  assign bus.perf_cycles = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gate_pair_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_gate_pair_sequencer
// Description : Self-checking bench for gate_pair_sequencer. The bench
//               contains a state RAM model, an applicator model (swap, or
//               sum/difference) and a timeline model of the expected outputs.
//               The model computes the outputs for each cycle, counted from
//               the accepted start.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_gate_pair_sequencer;
  import gate_pair_sequencer_pkg::*;

  localparam int NQ  = 3;
  localparam int AL  = 4;
  localparam int NS  = 1 << NQ;
  localparam int P   = NS / 2;
  localparam int LAT = 2 + AL;
`ifdef GATE_SEQ_PERF_COUNTER_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gate_pair_sequencer_if #(.NUM_QUBITS(NQ)) bus ();

  gate_pair_sequencer #(.NUM_QUBITS(NQ), .APP_LATENCY(AL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- state RAM model ----------------
  complex_t mem [NS];
  complex_t init_img [NS];
  logic     load_pulse = 1'b0;
  always @(posedge clk) begin
    if (load_pulse) begin
      for (int i = 0; i < NS; i++) mem[i] <= init_img[i];
    end else begin
      if (bus.rd_en) begin
        bus.rd_data_a <= mem[bus.rd_addr_a];
        bus.rd_data_b <= mem[bus.rd_addr_b];
      end
      if (bus.wr_en) begin
        mem[bus.wr_addr_a] <= bus.wr_data_a;
        mem[bus.wr_addr_b] <= bus.wr_data_b;
      end
    end
  end

  // ---------------- applicator model ----------------
  int umode = 0;
  function automatic logic [63:0] u_gate(input int m, input complex_t a, input complex_t b);
    complex_t o1, o2;
    if (m == 0) begin
      o1 = b; o2 = a;
    end else begin
      o1.re = a.re + b.re; o1.im = a.im + b.im;
      o2.re = a.re - b.re; o2.im = a.im - b.im;
    end
    return {o1, o2};
  endfunction

  logic [63:0] app_pipe [AL];
  always @(posedge clk) begin
    app_pipe[0] <= u_gate(umode, bus.app_in_1, bus.app_in_2);
    for (int k = 1; k < AL; k++) app_pipe[k] <= app_pipe[k-1];
  end
  assign bus.app_out_1 = app_pipe[AL-1][63:32];
  assign bus.app_out_2 = app_pipe[AL-1][31:0];

  // The j-th address, in ascending order, whose bit t is clear.
  function automatic int pair_lo(input int t, input int j);
    int n;
    n = 0;
    for (int i = 0; i < NS; i++) begin
      if (((i >> t) & 1) == 0) begin
        if (n == j) return i;
        n++;
      end
    end
    return -1;
  endfunction

  // ---------------- timeline model + compare ----------------
  bit       op_active = 1'b0;
  bit       op_inv    = 1'b0;
  int       op_s      = 0;
  int       op_t      = 0;
  bit       prev_err  = 1'b0;
  int       prev_perf = 0;
  bit       cur_err   = 1'b0;
  int       cur_perf  = 0;
  complex_t mem0 [NS];
  int       obs_a[$];
  int       obs_b[$];
  int       first_wr_rel = -1;
  int       done_rel     = -1;
  bit       busy_seen    = 1'b0;

  always @(negedge clk) begin : cmp
    int rel, a, b, e_perf;
    bit e_rd, e_wr, e_busy, e_done, e_app, e_err;
    logic [63:0] uo;
    rel = cyc - op_s;
    e_rd = 0; e_wr = 0; e_busy = 0; e_done = 0; e_app = 0;
    e_err = prev_err; e_perf = prev_perf;
    if (op_active && rel >= 1) begin
      if (op_inv) begin
        e_done = (rel == 1); e_err = 1'b1; e_perf = 0;
      end else begin
        e_rd   = (rel <= P);
        e_wr   = (rel >= LAT + 1) && (rel <= P + LAT);
        e_busy = (rel <= P + LAT);
        e_done = (rel == P + LAT + 1);
        e_app  = (rel >= 3) && (rel <= P + 2);
        e_err  = 1'b0;
        e_perf = (rel - 1 < P + LAT) ? rel - 1 : P + LAT;
      end
    end
    if (!PERF_EN) e_perf = 0;
    cur_err = e_err; cur_perf = e_perf;

    chk("busy", bus.busy, e_busy);
    chk("done", bus.done, e_done);
    chk("err", bus.err, e_err);
    chk("rd_en", bus.rd_en, e_rd);
    chk("wr_en", bus.wr_en, e_wr);
    chk("perf_cycles", bus.perf_cycles, e_perf);
    if (e_rd) begin
      a = pair_lo(op_t, rel - 1); b = a + (1 << op_t);
      chk("rd_addr_a", bus.rd_addr_a, a);
      chk("rd_addr_b", bus.rd_addr_b, b);
    end
    if (e_app) begin
      a = pair_lo(op_t, rel - 3); b = a + (1 << op_t);
      chk("app_in_1", bus.app_in_1, mem0[a]);
      chk("app_in_2", bus.app_in_2, mem0[b]);
    end
    if (e_wr) begin
      a = pair_lo(op_t, rel - LAT - 1); b = a + (1 << op_t);
      uo = u_gate(umode, mem0[a], mem0[b]);
      chk("wr_addr_a", bus.wr_addr_a, a);
      chk("wr_addr_b", bus.wr_addr_b, b);
      chk("wr_data_a", bus.wr_data_a, uo[63:32]);
      chk("wr_data_b", bus.wr_data_b, uo[31:0]);
    end

    if (bus.rd_en) begin
      obs_a.push_back(int'(bus.rd_addr_a));
      obs_b.push_back(int'(bus.rd_addr_b));
    end
    if (bus.wr_en && first_wr_rel < 0) first_wr_rel = rel;
    if (bus.done && done_rel < 0) done_rel = rel;
    if (bus.busy) busy_seen = 1'b1;
  end

  // ---------------- stimulus helpers ----------------
  task automatic load_mem(input int seed);
    for (int i = 0; i < NS; i++) begin
      init_img[i].re = 16'(i);
      init_img[i].im = 16'(seed * 7 + i * 3);
    end
    @(posedge clk); #1;
    load_pulse = 1'b1;
    @(posedge clk); #1;
    load_pulse = 1'b0;
  endtask

  task automatic run_op(input int t, input bit hold, input bit abort);
    for (int i = 0; i < NS; i++) mem0[i] = mem[i];
    obs_a.delete(); obs_b.delete();
    first_wr_rel = -1; done_rel = -1; busy_seen = 1'b0;
    @(posedge clk); #1;
    prev_err = cur_err; prev_perf = cur_perf;
    op_s = cyc; op_t = t; op_inv = (t >= NQ); op_active = 1'b1;
    bus.start = 1'b1;
    bus.target_qubit = 2'(t);
    @(posedge clk); #1;               // cycle 1
    if (!hold) bus.start = 1'b0;
    if (abort) begin
      repeat (2) @(posedge clk); #1;  // cycle 3
      rst = 1'b1;
      op_active = 1'b0; prev_err = 1'b0; prev_perf = 0;
      #1;
      chk("abort_busy", bus.busy, 0);
      chk("abort_rd_en", bus.rd_en, 0);
      chk("abort_app_in_1", bus.app_in_1, 0);
      chk("abort_rd_addr_a", bus.rd_addr_a, 0);
      repeat (2) @(posedge clk); #1;
      rst = 1'b0;
      repeat (P + LAT + 4) @(posedge clk);
    end else begin
      repeat (P + LAT) @(posedge clk); #1;   // done cycle
      bus.start = 1'b0;
      repeat (4) @(posedge clk);
    end
    #1;
  endtask

  task automatic check_mem(input string tag, input bit changed);
    int a, b;
    logic [63:0] o;
    for (int j = 0; j < P; j++) begin
      a = pair_lo(op_t, j); b = a + (1 << op_t);
      o = changed ? u_gate(umode, mem0[a], mem0[b]) : {mem0[a], mem0[b]};
      chk(tag, mem[a], o[63:32]);
      chk(tag, mem[b], o[31:0]);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lit_a [P];
    int lit_b [P];
    bus.start = 1'b0;
    bus.target_qubit = '0;

    // Reset state
    repeat (2) @(posedge clk); #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_rd_en", bus.rd_en, 0);
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_wr_data_a", bus.wr_data_a, 0);
    chk("rst_app_in_2", bus.app_in_2, 0);
    chk("rst_perf", bus.perf_cycles, 0);
    rst = 1'b0;

    // Target 0 with the sum/difference applicator. Pins pair order and timing.
    umode = 1;
    load_mem(1);
    run_op(0, 1'b0, 1'b0);
    lit_a = '{0, 2, 4, 6}; lit_b = '{1, 3, 5, 7};
    chk("t0_rd_count", obs_a.size(), 4);
    for (int j = 0; j < P && j < obs_a.size(); j++) begin
      chk("t0_pair_a", obs_a[j], lit_a[j]);
      chk("t0_pair_b", obs_b[j], lit_b[j]);
    end
    chk("t0_first_wr_cycle", first_wr_rel, 7);
    chk("t0_done_cycle", done_rel, 11);
    chk("t0_perf", bus.perf_cycles, PERF_EN ? 10 : 0);
    check_mem("t0_mem", 1'b1);

    // Target 2 with a swap applicator: final amp[i].re must equal i XOR 4.
    umode = 0;
    load_mem(2);
    run_op(2, 1'b0, 1'b0);
    lit_a = '{0, 1, 2, 3}; lit_b = '{4, 5, 6, 7};
    chk("t2_rd_count", obs_a.size(), 4);
    for (int j = 0; j < P && j < obs_a.size(); j++) begin
      chk("t2_pair_a", obs_a[j], lit_a[j]);
      chk("t2_pair_b", obs_b[j], lit_b[j]);
    end
    for (int i = 0; i < NS; i++) chk("t2_swap_re", mem[i].re, 16'(i ^ 4));

    // Out-of-range target
    run_op(3, 1'b0, 1'b0);
    chk("inv_done_cycle", done_rel, 1);
    chk("inv_rd_count", obs_a.size(), 0);
    chk("inv_wr_seen", first_wr_rel, -1);
    chk("inv_busy_seen", busy_seen, 0);
    chk("inv_err_held", bus.err, 1);
    check_mem("inv_mem", 1'b0);

    // start held through the whole operation gives exactly one operation.
    umode = 1;
    load_mem(3);
    run_op(1, 1'b1, 1'b0);
    repeat (5) @(posedge clk); #1;
    chk("hold_rd_count", obs_a.size(), 4);
    check_mem("hold_mem", 1'b1);

    // A fresh start after done works normally.
    run_op(1, 1'b0, 1'b0);
    chk("again_rd_count", obs_a.size(), 4);
    check_mem("again_mem", 1'b1);

    // Reset at cycle 3 aborts the operation, and no write-back follows.
    load_mem(4);
    run_op(0, 1'b0, 1'b1);
    chk("abort_wr_seen", first_wr_rel, -1);
    check_mem("abort_mem", 1'b0);

    // Normal operation after the abort
    umode = 0;
    run_op(2, 1'b0, 1'b0);
    chk("post_abort_done_cycle", done_rel, 11);
    check_mem("post_abort_mem", 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
